// File: rtl/serial_alu_ctrl_if.sv
// Bus between the register-file side (master) and the bit-serial ALU
// sequencer (slave). Handshake: the master raises start with op/a/b valid;
// the slave samples them only while idle, holds busy high until the operation
// retires, and pulses done for exactly one cycle when result and flags become
// valid. Results and flags then hold until the next done.
interface serial_alu_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             illegal;
  logic [1:0]       fsm_state;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carryout, overflow, zero, illegal, fsm_state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carryout, overflow, zero, illegal, fsm_state
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: decodes a 3-bit opcode into 1-bit slice controls,
// streams the captured operands LSB-first through one AND/OR/ADD slice with a
// registered carry, then publishes the result and flags with a done pulse.
module serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_alu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             ainv, binv;
  logic [1:0]       oper;
  logic [2:0]       op_q;
  logic             busy_q, done_q, carryout_q, overflow_q, zero_q, illegal_q;
  logic [WIDTH-1:0] result_q;

  // Opcode decode into slice controls.
  logic       dec_ainv, dec_binv, dec_cin, dec_illegal;
  logic [1:0] dec_oper;

  // Combinational decode of the incoming opcode.
  always_comb begin
    dec_ainv    = 1'b0;
    dec_binv    = 1'b0;
    dec_cin     = 1'b0;
    dec_oper    = 2'b00;
    dec_illegal = 1'b0;
    case (bus.op)
      3'b000: dec_oper = 2'b00;
      3'b001: dec_oper = 2'b01;
      3'b010: dec_oper = 2'b10;
      3'b110, 3'b111: begin
        dec_binv = 1'b1;
        dec_cin  = 1'b1;
        dec_oper = 2'b10;
      end
      3'b100: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // The 1-bit slice operating on the current LSBs and the carry flop.
  logic a_p, b_p, sum_bit, slice_out, slice_cout;
  logic [WIDTH-1:0] full_res, final_res;
  logic             ovf_bit, final_co, final_ovf;

  // Slice output plus the flag/result selection used on the last bit.
  always_comb begin
    a_p        = a_sh[0] ^ ainv;
    b_p        = b_sh[0] ^ binv;
    sum_bit    = a_p ^ b_p ^ carry;
    slice_cout = (a_p & b_p) | (a_p & carry) | (b_p & carry);
    case (oper)
      2'b00:   slice_out = a_p & b_p;
      2'b01:   slice_out = a_p | b_p;
      default: slice_out = sum_bit;
    endcase
    full_res = {slice_out, res_sh[WIDTH-1:1]};
    // On the MSB the carry flop holds the carry into the MSB.
    ovf_bit  = carry ^ slice_cout;
    final_res = full_res;
    final_co  = 1'b0;
    final_ovf = 1'b0;
    case (op_q)
      3'b010, 3'b110: begin
        final_co  = slice_cout;
        final_ovf = ovf_bit;
      end
      3'b111: begin
        final_res = {{(WIDTH-1){1'b0}}, slice_out ^ ovf_bit};
        final_ovf = ovf_bit;
      end
      3'b011, 3'b101: final_res = '0;
      default: ;
    endcase
  end

  // Sequencer: capture in IDLE, one bit per cycle in RUN, publish on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      ainv       <= 1'b0;
      binv       <= 1'b0;
      oper       <= 2'b00;
      op_q       <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            op_q   <= bus.op;
            ainv   <= dec_ainv;
            binv   <= dec_binv;
            oper   <= dec_oper;
            carry  <= dec_cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sh <= full_res;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result_q   <= final_res;
            carryout_q <= final_co;
            overflow_q <= final_ovf;
            zero_q     <= (final_res == '0);
            illegal_q  <= (op_q == 3'b011) || (op_q == 3'b101);
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carryout  = carryout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with hand-computed expected values.
module tb_serial_alu_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   lat;
  logic [WIDTH-1:0] exp_q[$];

  serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_ctrl #(.WIDTH(WIDTH), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally keep start high and scramble inputs while busy.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    check_val("busy_rise", bus.busy, 1);
    if (hold) begin
      bus.op = 3'b001;
      bus.a  = ~x;
      bus.b  = ~y;
    end else begin
      bus.start = 1'b0;
    end
    while (!bus.done && lat < WIDTH + 6) begin
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check_val("latency", lat, WIDTH + 1);
  endtask

  // Scoreboard: compare result/flags in the done cycle, then confirm the pulse ends.
  task automatic check_op(input string tag, input logic [7:0] res, input logic co,
                          input logic ov, input logic ill);
    logic [WIDTH-1:0] e;
    exp_q.push_back(res);
    e = exp_q.pop_front();
    check_val({tag, "_result"}, bus.result, e);
    check_val({tag, "_carry"}, bus.carryout, co);
    check_val({tag, "_ovf"}, bus.overflow, ov);
    check_val({tag, "_zero"}, bus.zero, (e == 0));
    check_val({tag, "_illegal"}, bus.illegal, ill);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, bus.done, 0);
    check_val({tag, "_busy_fall"}, bus.busy, 0);
  endtask

  initial begin
    bit seen_done;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_result", bus.result, 0);
    check_val("rst_state", bus.fsm_state, 0);
    rst_n = 1'b1;

    run_op(3'b010, 8'h7F, 8'h01, 0); check_op("add_ovf", 8'h80, 0, 1, 0);
    run_op(3'b110, 8'h05, 8'h03, 0); check_op("sub_pos", 8'h02, 1, 0, 0);
    run_op(3'b110, 8'h03, 8'h05, 0); check_op("sub_neg", 8'hFE, 0, 0, 0);
    run_op(3'b111, 8'hFB, 8'h03, 0); check_op("slt_lt", 8'h01, 0, 0, 0);
    run_op(3'b111, 8'h80, 8'h01, 0); check_op("slt_ovf", 8'h01, 0, 1, 0);
    run_op(3'b111, 8'h03, 8'hFB, 0); check_op("slt_ge", 8'h00, 0, 0, 0);
    run_op(3'b000, 8'hF0, 8'h3C, 0); check_op("and", 8'h30, 0, 0, 0);
    run_op(3'b001, 8'hF0, 8'h3C, 0); check_op("or", 8'hFC, 0, 0, 0);
    run_op(3'b100, 8'hF0, 8'h3C, 0); check_op("nor", 8'h03, 0, 0, 0);
    run_op(3'b100, 8'hF0, 8'h0F, 0); check_op("nor_zero", 8'h00, 0, 0, 0);
    run_op(3'b010, 8'h10, 8'h20, 1); check_op("hold_start", 8'h30, 0, 0, 0);
    run_op(3'b011, 8'h12, 8'h34, 0); check_op("illegal_011", 8'h00, 0, 0, 1);
    run_op(3'b101, 8'h12, 8'h34, 0); check_op("illegal_101", 8'h00, 0, 0, 1);
    run_op(3'b010, 8'h12, 8'h34, 0); check_op("add_plain", 8'h46, 0, 0, 0);

    // Abort an ADD in its 4th RUN cycle with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b010;
    bus.a = 8'h11;
    bus.b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_done", bus.done, 0);
    check_val("abort_result", bus.result, 0);
    check_val("abort_zero", bus.zero, 0);
    check_val("abort_state", bus.fsm_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check_val("abort_no_done", seen_done, 0);

    run_op(3'b010, 8'hFF, 8'h01, 0); check_op("add_wrap", 8'h00, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
